// File: rtl/shift_pkg.sv
// Shared state and select encodings for the shift-register sequencer.
package shift_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_LEFT  = 2'b01;
    localparam logic [1:0] SEL_RIGHT = 2'b10;
    localparam logic [1:0] SEL_LOAD  = 2'b11;

endpackage

// File: rtl/shift_seq.sv
// Sequences load + SHIFT_LEN shift cycles of an external 4-bit universal shift register per accepted word.
// Latency: handshake at edge N -> load cycle N+1, shifts N+2..N+1+SHIFT_LEN, done N+2+SHIFT_LEN.
// Backpressure: in_ready only in IDLE; input is ignored while a word is in flight.
module shift_seq
    import shift_pkg::*;
#(
    parameter int SHIFT_LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_dir,
    input  logic       in_fill,
    output logic       select1,
    output logic       select0,
    output logic       p_in0,
    output logic       p_in1,
    output logic       p_in2,
    output logic       p_in3,
    output logic       left_shift_inp,
    output logic       right_shift_inp,
    output logic       busy,
    output logic       done
);

    localparam int CW = (SHIFT_LEN < 1) ? 1 : $clog2(SHIFT_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(SHIFT_LEN);

    state_t        state;
    logic [1:0]    sel_q;
    logic [3:0]    word_q;
    logic          dir_q;
    logic          fill_q;
    logic          shift_inp_q;
    logic          busy_q;
    logic          done_q;
    logic [CW-1:0] cnt;

    // Every output is decided one edge early so it is a plain flop at the downstream negedge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            sel_q       <= SEL_HOLD;
            word_q      <= '0;
            dir_q       <= 1'b0;
            fill_q      <= 1'b0;
            shift_inp_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cnt         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        word_q <= in_data;
                        dir_q  <= in_dir;
                        fill_q <= in_fill;
                        sel_q  <= SEL_LOAD;
                        busy_q <= 1'b1;
                        state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (SHIFT_LEN == 0) begin
                        sel_q  <= SEL_HOLD;
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        sel_q       <= dir_q ? SEL_RIGHT : SEL_LEFT;
                        shift_inp_q <= fill_q;
                        cnt         <= CW'(1);
                        state       <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // cnt numbers the shift being issued, so it tops out at SHIFT_LEN
                    if (cnt == LAST) begin
                        sel_q       <= SEL_HOLD;
                        shift_inp_q <= 1'b0;
                        done_q      <= 1'b1;
                        cnt         <= '0;
                        state       <= ST_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Gated by rst_n so ready drops immediately on reset and rises in the first cycle after it.
    assign in_ready        = rst_n && (state == ST_IDLE);
    assign select1         = sel_q[1];
    assign select0         = sel_q[0];
    assign p_in0           = word_q[0];
    assign p_in1           = word_q[1];
    assign p_in2           = word_q[2];
    assign p_in3           = word_q[3];
    assign left_shift_inp  = shift_inp_q;
    assign right_shift_inp = shift_inp_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule
